stream_to_sdram_writer: RTL
===========================

// Module: stream_to_sdram_writer
// PURPOSE
//  FPGA-side Avalon-ST sink that captures a word stream and writes it into HPS DDR3
//  through the soc_system FPGA-to-SDRAM Avalon-MM port, as a burst-write master.
//  Software programs the base address and length, then pulses start; the block buffers
//  the stream and issues aligned bursts until the length is written, then pulses done.
// PARAMETERS
//  DATA_W      64   stream and Avalon-MM data width, bits (power of 2, >=8)
//  ADDR_W      32   Avalon-MM byte address width
//  LEN_W       24   transfer length width, in DATA_W words
//  BURST_MAX   16   maximum burstcount (power of 2, <=FIFO_DEPTH)
//  FIFO_DEPTH  32   internal buffer depth, words (power of 2)
// PORTS
//  clk_clk         in   1          single clock for all logic
//  reset_reset_n   in   1          synchronous active-low reset
//  start           in   1          1-cycle pulse; latches base_addr/length when idle
//  base_addr       in   ADDR_W     byte address; must be BURST_MAX*DATA_W/8 aligned
//  length          in   LEN_W      words to write (0 allowed)
//  busy            out  1          high from accepted start until done
//  done            out  1          1-cycle pulse at completion
//  snk_data        in   DATA_W     Avalon-ST data
//  snk_valid       in   1          Avalon-ST valid
//  snk_ready       out  1          Avalon-ST ready (readyLatency 0)
//  avm_address     out  ADDR_W     byte address of burst first beat
//  avm_burstcount  out  clog2(BURST_MAX)+1  beats in current burst
//  avm_write       out  1          write request / beat valid
//  avm_writedata   out  DATA_W     beat data
//  avm_byteenable  out  DATA_W/8   always all ones
//  avm_waitrequest in   1          slave stall
// BEHAVIOUR
//  Reset: all outputs 0 except avm_byteenable (all ones); FIFO emptied; state IDLE;
//   reset mid-transfer abandons it without done; an open burst is cut short.
//  States: IDLE -> (start, length!=0) WAIT_DATA; IDLE -> (start, length==0) DONE.
//   WAIT_DATA -> BURST when fifo_count >= n, n = min(BURST_MAX, words_left_to_write).
//   BURST -> WAIT_DATA after the last beat is accepted (avm_write & !avm_waitrequest)
//   while words remain; -> DONE if none remain. DONE -> IDLE after 1 cycle (done=1).
//  start while busy is ignored. busy = (state != IDLE).
//  Sink: snk_ready = busy & !fifo_full & (accepted < length); beat taken when
//   snk_valid & snk_ready. Words beyond length are never accepted (ready stays 0).
//  Burst: avm_address/avm_burstcount set on entry to BURST and held constant for the
//   whole burst; avm_write stays high every BURST cycle (no bubbles; FIFO holds >= n).
//   A beat completes on avm_write & !avm_waitrequest: FIFO pops, next word is presented.
//   While avm_waitrequest=1 all avm_* outputs hold.
//   Next address = previous + n*DATA_W/8, modulo 2^ADDR_W (wraps silently).
//  Sizing: first bursts are BURST_MAX; only the final burst may be shorter (length mod BURST_MAX).
//  Latency: first avm_write no earlier than 1 cycle after the n-th word is accepted;
//   done asserts the cycle after the final beat is accepted.
//  Simultaneous push and pop in one cycle keep fifo_count unchanged; full/empty are
//   exact (no almost-full slack). Counters: accepted and written are LEN_W bits.
// STRUCTURE
//  Package fpedge_stream_pkg: state enum (IDLE, WAIT_DATA, BURST, DONE),
//   DATA_W/ADDR_W/LEN_W defaults, BYTES_PER_WORD and BURSTCOUNT_W constants.
//  Sub-module: sync_fifo (DATA_W x FIFO_DEPTH, show-ahead, full/empty/count).
//  Top: FSM, accepted/written counters, burst address/size registers.
// TESTING
//  1 length=40, base=0x100, stream always valid, no waitrequest -> bursts (0x100,16),
//    (0x180,16), (0x200,8); data in order; done one cycle after last beat.
//  2 length=0 start -> no avm_write, busy 1 cycle later low, done pulses once.
//  3 waitrequest random 50% during bursts -> address/burstcount/data stable while
//    stalled; 64 words written exactly once, in order.
//  4 length=20, source offers 30 words -> snk_ready low after 20th accepted; words
//    21-30 never taken; bursts 16 then 4.
//  5 start pulsed mid-transfer with new base/length -> ignored; original transfer
//    completes unchanged.
//  6 reset_reset_n low mid-burst (beat 5 of 16) -> next cycle all outputs 0, busy 0,
//    no done; new start afterwards runs a clean transfer from its base.

Source files
------------

// File: rtl/fpedge_stream_pkg.sv
// ---------------------------------------------------------------------------
// fpedge_stream_pkg
// Shared definitions for the FPGA-side stream-to-SDRAM writer.
//   - default widths/depths used as parameter defaults by the writer
//   - derived constants (bytes per word, burstcount width)
//   - writer FSM state enumeration
// No ports (package).
// ---------------------------------------------------------------------------
package fpedge_stream_pkg;

  localparam int DEFAULT_DATA_W     = 64;
  localparam int DEFAULT_ADDR_W     = 32;
  localparam int DEFAULT_LEN_W      = 24;
  localparam int DEFAULT_BURST_MAX  = 16;
  localparam int DEFAULT_FIFO_DEPTH = 32;

  localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;
  localparam int BURSTCOUNT_W   = $clog2(DEFAULT_BURST_MAX) + 1;

  // Writer control states: idle, collecting enough words for the next burst,
  // streaming a burst out, and the single-cycle completion state.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: the head word is always visible on pop_data
// while the FIFO is non-empty, and a pop simply advances to the next word.
// Full and empty are exact; a simultaneous push and pop keeps count unchanged.
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset (empties the FIFO)
//   push       in   write request (ignored when full)
//   push_data  in   WIDTH word to write
//   pop        in   read-advance request (ignored when empty)
//   pop_data   out  WIDTH head word (show-ahead)
//   full       out  no free entries
//   empty      out  no stored entries
//   count      out  number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Requests are qualified here so callers can never overrun or underrun
  // the storage, even if their own gating is wrong.
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking. DEPTH is a power of two, so the
  // pointers wrap naturally at their width. Reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, kept out of the reset domain so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/stream_to_sdram_writer.sv
// ---------------------------------------------------------------------------
// stream_to_sdram_writer
// Avalon-ST sink that buffers a word stream and writes it to HPS SDRAM through
// an Avalon-MM burst-write master. Software sets base_addr/length and pulses
// start; the block issues aligned bursts (BURST_MAX beats, last one shorter)
// until length words are written, then pulses done.
// Ports:
//   clk_clk          in   clock
//   reset_reset_n    in   synchronous active-low reset
//   start            in   1-cycle pulse, accepted only when idle
//   base_addr        in   ADDR_W byte address (burst aligned)
//   length           in   LEN_W words to write (0 allowed)
//   busy             out  high from accepted start until done
//   done             out  1-cycle completion pulse
//   snk_data         in   DATA_W stream data
//   snk_valid        in   stream valid
//   snk_ready        out  stream ready (readyLatency 0)
//   avm_address      out  ADDR_W byte address of the burst's first beat
//   avm_burstcount   out  beats in current burst
//   avm_write        out  write request / beat valid
//   avm_writedata    out  DATA_W beat data
//   avm_byteenable   out  always all ones
//   avm_waitrequest  in   slave stall
// ---------------------------------------------------------------------------
module stream_to_sdram_writer
  import fpedge_stream_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int LEN_W      = DEFAULT_LEN_W,
  parameter int BURST_MAX  = DEFAULT_BURST_MAX,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [LEN_W-1:0]               length,
  output logic                           busy,
  output logic                           done,
  input  logic [DATA_W-1:0]              snk_data,
  input  logic                           snk_valid,
  output logic                           snk_ready,
  output logic [ADDR_W-1:0]              avm_address,
  output logic [$clog2(BURST_MAX):0]     avm_burstcount,
  output logic                           avm_write,
  output logic [DATA_W-1:0]              avm_writedata,
  output logic [DATA_W/8-1:0]            avm_byteenable,
  input  logic                           avm_waitrequest
);

  localparam int BC_W       = $clog2(BURST_MAX) + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

  state_t            state;
  logic [LEN_W-1:0]  length_r;
  logic [LEN_W-1:0]  accepted;
  logic [LEN_W-1:0]  written;
  logic [LEN_W-1:0]  words_left;
  logic [ADDR_W-1:0] burst_addr;
  logic [BC_W-1:0]   beats_left;
  logic [BC_W-1:0]   next_n;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Stream acceptance stops exactly at length, so surplus source words are
  // left with the source rather than silently dropped.
  assign busy      = (state != IDLE);
  assign snk_ready = busy & ~fifo_full & (accepted < length_r);
  assign push      = snk_valid & snk_ready;

  // A beat completes when the slave is not stalling. The FIFO is guaranteed
  // to hold the whole burst before BURST is entered, so empty is only a guard.
  assign pop = (state == BURST) & avm_write & ~avm_waitrequest & ~fifo_empty;

  // Size of the next burst: full bursts until the tail, then the remainder.
  // The remainder is below BURST_MAX, so it fits in the burstcount width.
  assign words_left = length_r - written;
  assign next_n = (words_left >= LEN_W'(BURST_MAX)) ? BC_W'(BURST_MAX)
                                                     : words_left[BC_W-1:0];

  assign avm_byteenable = '1;

  // Data is zero whenever no write is requested so the bus is quiet after
  // reset even though the FIFO storage itself is not cleared.
  assign avm_writedata = avm_write ? fifo_data : '0;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .reset_n   (reset_reset_n),
    .push      (push),
    .push_data (snk_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Control FSM with its counters and registered Avalon-MM outputs.
  // Address and burstcount are loaded once on entry to BURST and held for
  // the whole burst; avm_write stays high until the final beat completes,
  // so a stalled slave always sees stable request signals. The next burst
  // address is precomputed on entry and wraps modulo 2^ADDR_W. A reset
  // abandons any transfer in flight without producing done.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      length_r       <= '0;
      accepted       <= '0;
      written        <= '0;
      burst_addr     <= '0;
      beats_left     <= '0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      avm_write      <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) begin
        accepted <= accepted + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            length_r   <= length;
            accepted   <= '0;
            written    <= '0;
            burst_addr <= base_addr;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (32'(fifo_count) >= 32'(next_n)) begin
            state          <= BURST;
            avm_write      <= 1'b1;
            avm_address    <= burst_addr;
            avm_burstcount <= next_n;
            beats_left     <= next_n;
            burst_addr     <= burst_addr + (ADDR_W'(next_n) << BYTE_SHIFT);
          end
        end
        BURST: begin
          if (pop) begin
            written    <= written + LEN_W'(1);
            beats_left <= beats_left - BC_W'(1);
            if (beats_left == BC_W'(1)) begin
              avm_write <= 1'b0;
              if (written + LEN_W'(1) == length_r) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= WAIT_DATA;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
